// File: rtl/chip8_display_buffer.sv
`default_nettype none
// chip8_display_buffer: 64x32 CHIP-8 framebuffer, XOR sprite draw engine, 2-cycle pipelined HDMI read port.
// Define CHIP8_SPRITE_WRAP_EN to wrap sprites at the screen edges instead of clipping them.
module chip8_display_buffer (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic        cmd_clear_in,
    input  logic [5:0]  cmd_x_in,
    input  logic [4:0]  cmd_y_in,
    input  logic [3:0]  cmd_n_in,
    output logic        row_req_out,
    output logic [3:0]  row_index_out,
    input  logic        row_valid_in,
    input  logic [7:0]  row_data_in,
    output logic        done_out,
    output logic        collision_out,
    input  logic [15:0] hdmi_addr_in,
    output logic [7:0]  hdmi_data_out
);

`ifdef CHIP8_SPRITE_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CLEAR    = 4'd1,
        FETCH    = 4'd2,
        WAIT_ROW = 4'd3,
        RD0      = 4'd4,
        WR0      = 4'd5,
        RD1      = 4'd6,
        WR1      = 4'd7,
        DONE     = 4'd8
    } state_t;

    state_t      state;
    logic [7:0]  mem [256];
    logic [5:0]  x;
    logic [4:0]  y;
    logic [3:0]  n;
    logic [3:0]  row;
    logic [7:0]  clr_cnt;
    logic [15:0] shift;
    logic [7:0]  old;
    logic        collision;
    logic [7:0]  rd_pipe;

    logic [4:0]  row_y;
    logic [2:0]  byte0;
    logic [2:0]  byte1;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [5:0]  row_y_full;
    logic        second_needed;
    logic        finish_cmd;

    logic        we;
    logic [7:0]  waddr;
    logic [7:0]  wdata;

    assign row_y      = y + {1'b0, row};
    assign row_y_full = {1'b0, y} + {2'b00, row};
    assign byte0      = x[5:3];
    assign byte1      = x[5:3] + 3'd1;
    assign addr0      = {row_y, byte0};
    assign addr1      = {row_y, byte1};

    // The right-hand byte is only touched when the shifted sprite spills into it.
    assign second_needed = (shift[7:0] != 8'h00) && (WRAP_EN || (byte0 != 3'd7));

`ifdef CHIP8_SPRITE_WRAP_EN
    assign finish_cmd = (row == n - 4'd1);
`else
    assign finish_cmd = (row == n - 4'd1) || (row_y_full >= 6'd31);
`endif

    assign cmd_ready_out = (state == IDLE);
    assign row_req_out   = (state == FETCH);
    assign done_out      = (state == DONE);
    assign row_index_out = row;
    assign collision_out = collision;

    always_comb begin
        we    = 1'b0;
        waddr = addr0;
        wdata = old ^ shift[15:8];
        case (state)
            CLEAR: begin
                we    = 1'b1;
                waddr = clr_cnt;
                wdata = 8'h00;
            end
            WR0: begin
                we = 1'b1;
            end
            WR1: begin
                we    = 1'b1;
                waddr = addr1;
                wdata = old ^ shift[7:0];
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

    // Framebuffer storage is deliberately not reset; CLEAR initialises it.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of mem gives read-first behaviour against a same-cycle write.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_pipe       <= 8'h00;
            hdmi_data_out <= 8'h00;
        end else begin
            rd_pipe       <= mem[hdmi_addr_in[7:0]];
            hdmi_data_out <= rd_pipe;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            x         <= 6'd0;
            y         <= 5'd0;
            n         <= 4'd0;
            row       <= 4'd0;
            clr_cnt   <= 8'd0;
            shift     <= 16'h0000;
            old       <= 8'h00;
            collision <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_in) begin
                        x         <= cmd_x_in;
                        y         <= cmd_y_in;
                        n         <= cmd_n_in;
                        row       <= 4'd0;
                        clr_cnt   <= 8'd0;
                        collision <= 1'b0;
                        if (cmd_clear_in) begin
                            state <= CLEAR;
                        end else if (cmd_n_in == 4'd0) begin
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 8'd1;
                    if (clr_cnt == 8'hFF) begin
                        state <= DONE;
                    end
                end
                FETCH: begin
                    state <= WAIT_ROW;
                end
                WAIT_ROW: begin
                    if (row_valid_in) begin
                        shift <= {row_data_in, 8'h00} >> x[2:0];
                        state <= RD0;
                    end
                end
                RD0: begin
                    old   <= mem[addr0];
                    state <= WR0;
                end
                WR0: begin
                    if ((old & shift[15:8]) != 8'h00) begin
                        collision <= 1'b1;
                    end
                    if (second_needed) begin
                        state <= RD1;
                    end else if (finish_cmd) begin
                        state <= DONE;
                    end else begin
                        row   <= row + 4'd1;
                        state <= FETCH;
                    end
                end
                RD1: begin
                    old   <= mem[addr1];
                    state <= WR1;
                end
                WR1: begin
                    if ((old & shift[7:0]) != 8'h00) begin
                        collision <= 1'b1;
                    end
                    if (finish_cmd) begin
                        state <= DONE;
                    end else begin
                        row   <= row + 4'd1;
                        state <= FETCH;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/chip8_display_buffer.md
CHIP8_DISPLAY_BUFFER -- requirements
Module: chip8_display_buffer

Interface
REQ-001 SHALL have port clk_in, input, 1, single clock for all logic.
REQ-002 SHALL have port rst_in, input, 1, reset, asynchronous assert, active-low.
REQ-003 SHALL have port cmd_valid_in, input, 1, command offered.
REQ-004 SHALL have port cmd_ready_out, output, 1, command accepted when valid&ready.
REQ-005 SHALL have port cmd_clear_in, input, 1, 1=clear screen, 0=draw sprite.
REQ-006 SHALL have ports cmd_x_in (6), cmd_y_in (5) and cmd_n_in (4), all inputs: sprite origin and row count.
REQ-007 SHALL have port row_req_out, output, 1, single-cycle request for one sprite row.
REQ-008 SHALL have port row_index_out, output, 4, row number (0..n-1), held until row_valid_in.
REQ-009 SHALL have ports row_valid_in (1) and row_data_in (8), both inputs: sprite row return, MSB = leftmost pixel.
REQ-010 SHALL have port done_out, output, 1, one-cycle pulse at command completion.
REQ-011 SHALL have port collision_out, output, 1, CHIP-8 VF result of the last draw.
REQ-012 SHALL have port hdmi_addr_in, input, 16, display byte address {y[4:0],xbyte[2:0]} in bits [7:0]; bits [15:8] ignored.
REQ-013 SHALL have port hdmi_data_out, output, 8, display byte, bit 7 = leftmost pixel.

Function
REQ-014 SHALL store 64x32 monochrome pixels as 256 bytes; byte address = y*8 + x/8.
REQ-015 SHALL return hdmi_data_out exactly 2 cycles after hdmi_addr_in is presented, fully pipelined (one read per cycle).
REQ-016 SHALL give the hdmi read port read-first semantics: a same-cycle write to the same byte returns old data.
REQ-017 SHALL assert cmd_ready_out only in IDLE; accept a command on valid&ready and latch x mod 64, y mod 32, n.
REQ-018 SHALL use states IDLE, CLEAR, FETCH, WAIT_ROW, RD0, WR0, RD1, WR1, DONE.
REQ-019 CLEAR: write 0x00 to addresses 0..255, one per cycle (256 cycles), then DONE; collision_out SHALL be 0.
REQ-020 Draw with n=0: go directly to DONE with collision_out=0.
REQ-021 FETCH: pulse row_req_out with row_index_out=r; WAIT_ROW holds until row_valid_in (any latency, including next cycle); row_valid_in outside WAIT_ROW SHALL be ignored.
REQ-022 Per row, form 16-bit s = {row_data,8'h00} >> (x mod 8); byte b = x/8 of row (y+r) receives XOR with s[15:8] (RD0/WR0); byte b+1 receives XOR with s[7:0] (RD1/WR1), skipped if s[7:0]==0.
REQ-023 Each read-modify-write SHALL take 2 cycles: read, then write old^mask.
REQ-024 Collision SHALL set if any (old & mask) != 0 for any byte of the command; cleared at command accept.
REQ-025 DONE: pulse done_out one cycle, return to IDLE; collision_out held until next command accepted.
REQ-026 Row count n=15 with y+r arithmetic SHALL use 5-bit row, 3-bit byte indices with edge handling per REQ-031.

Reset
REQ-027 On rst_in low: state=IDLE, cmd_ready_out=1 after release, row_req_out=0, done_out=0, collision_out=0, hdmi_data_out=0x00, read pipeline cleared.
REQ-028 Reset mid-command SHALL abort with no done_out pulse; memory contents not reset (undefined until CLEAR).

Configuration
REQ-029 Macro CHIP8_SPRITE_WRAP_EN SHALL select edge behaviour.
REQ-030 Defined: byte b+1 past byte 7 wraps to byte 0 of the same row; rows past y=31 wrap to row 0; all n rows fetched.
REQ-031 Undefined: pixels past x=63 discarded (RD1/WR1 skipped when b=7); rows with y+r>31 not fetched, command ends after last visible row.

Verification
REQ-032 CLEAR, then sweep hdmi_addr_in 0x00..0xFF -> hdmi_data_out 0x00 each, 2 cycles after address; done_out after 256 CLEAR cycles.
REQ-033 Draw x=0,y=0,n=1, row 0xF0 -> byte 0x00=0xF0, collision_out=0; repeat -> byte 0x00=0x00, collision_out=1.
REQ-034 Draw x=5,y=3,n=1, row 0xFF -> byte 0x18=0x07, byte 0x19=0xF8.
REQ-035 Draw x=60,y=31,n=2, rows 0xFF -> with WRAP_EN: 0xFF=0x0F, 0xF8=0xF0, 0x07=0x0F, 0x00=0xF0; without: only 0xFF=0x0F changes, one row_req_out.
REQ-036 row_valid_in delayed 5 cycles, spurious row_valid_in in IDLE -> no memory change; x=70 draws at x=6.
REQ-037 rst_in low during WAIT_ROW -> no done_out, cmd_ready_out=1 after release, next CLEAR completes normally.
